// File: rtl/fp64_pkg.sv
// Shared definitions for the iterative binary64 divider.
// Holds the format constants, the divider FSM state encoding, the
// unpacked-operand record and the operand unpack helper.
package fp64_pkg;

    localparam int          BIAS    = 1023;
    localparam logic [10:0] EXP_INF = 11'h7FF;
    localparam logic [63:0] QNAN    = 64'h7FF8000000000000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DIV   = 2'd1,
        ROUND = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic        sign;
        logic [10:0] exp;
        logic [52:0] mant;     // hidden 1 included
        logic        is_zero;  // exp==0, denormals flushed here
        logic        is_inf;
        logic        is_nan;
    } fp_unpacked_t;

    function automatic fp_unpacked_t fp_unpack(input logic [63:0] x);
        fp_unpacked_t u;
        u.sign    = x[63];
        u.exp     = x[62:52];
        u.mant    = {1'b1, x[51:0]};
        u.is_zero = (x[62:52] == 11'd0);
        u.is_inf  = (x[62:52] == EXP_INF) && (x[51:0] == 52'd0);
        u.is_nan  = (x[62:52] == EXP_INF) && (x[51:0] != 52'd0);
        return u;
    endfunction

endpackage

// File: rtl/fp64_div_iter_if.sv
// Handshake bundle for the divider: operand channel (in_valid/in_ready, a, b)
// and result channel (out_valid/out_ready, result, flag_dz, flag_inv).
// master = requester/consumer side, slave = divider side.
interface fp64_div_iter_if;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] result;
    logic        flag_dz;
    logic        flag_inv;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, result, flag_dz, flag_inv
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, result, flag_dz, flag_inv
    );
endinterface

// File: rtl/fp64_div_normround.sv
// Normalise / round-to-nearest-even / range-check for the divider.
// Ports:
//   sign_i    result sign
//   exp_i     biased exponent before normalisation (13-bit signed)
//   quot_i    56 quotient bits, quot_i[55] has weight 2^0
//   rem_nz_i  final remainder non-zero (sticky contribution)
//   result_o  packed binary64 result (inf on overflow, zero on underflow)
module fp64_div_normround
    import fp64_pkg::*;
(
    input  logic               sign_i,
    input  logic signed [12:0] exp_i,
    input  logic [55:0]        quot_i,
    input  logic               rem_nz_i,
    output logic [63:0]        result_o
);

    function automatic logic rne_up(input logic lsb, input logic g,
                                    input logic r, input logic s);
        return g & (r | s | lsb);
    endfunction

    logic [52:0]        mant;
    logic               g, r, s;
    logic [53:0]        mant_r;
    logic signed [12:0] exp_adj;

    always_comb begin
        // Quotient of two [1,2) mantissas lies in (0.5,2); shift once if <1.
        if (quot_i[55]) begin
            mant    = quot_i[55:3];
            g       = quot_i[2];
            r       = quot_i[1];
            s       = quot_i[0] | rem_nz_i;
            exp_adj = exp_i;
        end else begin
            mant    = quot_i[54:2];
            g       = quot_i[1];
            r       = quot_i[0];
            s       = rem_nz_i;
            exp_adj = exp_i - 13'sd1;
        end

        mant_r = {1'b0, mant} + 54'(rne_up(mant[0], g, r, s));
        // Carry out means the mantissa rounded up to 2.0: becomes 1.0, e+1.
        if (mant_r[53]) begin
            exp_adj = exp_adj + 13'sd1;
        end

        if (exp_adj >= 13'sd2047) begin
            result_o = {sign_i, EXP_INF, 52'd0};
        end else if (exp_adj <= 13'sd0) begin
            result_o = {sign_i, 63'd0};
        end else begin
            result_o = {sign_i, exp_adj[10:0], mant_r[51:0]};
        end
    end

endmodule

// File: rtl/fp64_div_iter.sv
// Iterative binary64 divider, radix-2 restoring, one quotient bit per cycle,
// round-to-nearest-even, denormals flushed to signed zero.
// Ports:
//   clk  clock
//   rst  synchronous active-high reset
//   bus  fp64_div_iter_if.slave: operand handshake (in_valid/in_ready, a, b)
//        and result handshake (out_valid/out_ready, result, flag_dz, flag_inv)
module fp64_div_iter
    import fp64_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    fp64_div_iter_if.slave    bus
);

    state_t             state_q, state_d;
    logic               sign_q;
    logic               a_zero_q, a_inf_q, a_nan_q;
    logic               b_zero_q, b_inf_q, b_nan_q;
    logic [52:0]        mb_q;
    logic [53:0]        rem_q;
    logic [55:0]        quot_q;
    logic [5:0]         cnt_q;
    logic signed [12:0] exp_q;
    logic [63:0]        result_q;
    logic               dz_q, inv_q;

    fp_unpacked_t       ua, ub;
    logic               accept;
    logic               first_div;
    logic               rem_ge;
    logic [53:0]        rem_sub;
    logic               is_special;
    logic [63:0]        spec_res;
    logic               spec_dz, spec_inv;
    logic [63:0]        nr_result;

    assign ua        = fp_unpack(bus.a);
    assign ub        = fp_unpack(bus.b);
    assign accept    = (state_q == IDLE) && bus.in_valid;
    // Operands are classified during the first DIV cycle from the captured
    // copies, so a special result appears one edge after acceptance.
    assign first_div = (state_q == DIV) && (cnt_q == 6'd55);

    always_comb begin
        spec_res   = 64'd0;
        spec_dz    = 1'b0;
        spec_inv   = 1'b0;
        is_special = 1'b1;
        if (a_nan_q || b_nan_q || (a_zero_q && b_zero_q) || (a_inf_q && b_inf_q)) begin
            spec_res = QNAN;
            spec_inv = 1'b1;
        end else if (b_zero_q && !a_inf_q) begin
            spec_res = {sign_q, EXP_INF, 52'd0};
            spec_dz  = 1'b1;
        end else if (a_inf_q) begin
            spec_res = {sign_q, EXP_INF, 52'd0};
        end else if (a_zero_q || b_inf_q) begin
            spec_res = {sign_q, 63'd0};
        end else begin
            is_special = 1'b0;
        end
    end

    // Restoring step: subtract when it fits, the shift happens on the register.
    assign rem_ge  = (rem_q >= {1'b0, mb_q});
    assign rem_sub = rem_ge ? (rem_q - {1'b0, mb_q}) : rem_q;

    fp64_div_normround u_normround (
        .sign_i   (sign_q),
        .exp_i    (exp_q),
        .quot_i   (quot_q),
        .rem_nz_i (rem_q != 54'd0),
        .result_o (nr_result)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid) state_d = DIV;
            DIV:     if (first_div && is_special) state_d = DONE;
                     else if (cnt_q == 6'd0)      state_d = ROUND;
            ROUND:   state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        bus.in_ready  = (state_q == IDLE) && !rst;
        bus.out_valid = (state_q == DONE);
        bus.result    = result_q;
        bus.flag_dz   = dz_q;
        bus.flag_inv  = inv_q;
    end

    // Datapath: operand capture and mantissa iteration
    always_ff @(posedge clk) begin
        if (accept) begin
            sign_q   <= ua.sign ^ ub.sign;
            a_zero_q <= ua.is_zero;
            a_inf_q  <= ua.is_inf;
            a_nan_q  <= ua.is_nan;
            b_zero_q <= ub.is_zero;
            b_inf_q  <= ub.is_inf;
            b_nan_q  <= ub.is_nan;
            mb_q     <= ub.mant;
            rem_q    <= {1'b0, ua.mant};
            cnt_q    <= 6'd55;
            exp_q    <= $signed({2'b00, ua.exp}) - $signed({2'b00, ub.exp})
                        + $signed(13'(BIAS));
        end else if (state_q == DIV) begin
            rem_q  <= rem_sub << 1;
            quot_q <= {quot_q[54:0], rem_ge};
            cnt_q  <= cnt_q - 6'd1;
        end
    end

    // Result and flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= 64'd0;
            dz_q     <= 1'b0;
            inv_q    <= 1'b0;
        end else if (first_div && is_special) begin
            result_q <= spec_res;
            dz_q     <= spec_dz;
            inv_q    <= spec_inv;
        end else if (state_q == ROUND) begin
            result_q <= nr_result;
            dz_q     <= 1'b0;
            inv_q    <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fp64_div_iter.sv
// Directed bench for fp64_div_iter: normal quotients, rounding, specials,
// range limits, backpressure and mid-operation reset.
module tb_fp64_div_iter;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    fp64_div_iter_if bus ();

    fp64_div_iter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_eq(input string tag, input logic [63:0] got,
                          input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one op, wait for the result, check latency/result/flags.
    // hold > 0: out_ready is kept low (caller sets it) for hold cycles
    // after out_valid while a competing in_valid is presented.
    task automatic run_op(input string tag, input logic [63:0] a,
                          input logic [63:0] b, input logic [63:0] exp_res,
                          input logic exp_dz, input logic exp_inv,
                          input int exp_lat, input int hold);
        int lat;
        @(negedge clk);
        chk_eq({tag, "_rdy0"}, 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b1;
        bus.a = a;
        bus.b = b;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.a = {$urandom, $urandom};
        bus.b = {$urandom, $urandom};
        lat = 0;
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk_eq({tag, "_valid"}, 64'(bus.out_valid), 64'd1);
        chk_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk_eq({tag, "_res"}, bus.result, exp_res);
        chk_eq({tag, "_dz"}, 64'(bus.flag_dz), 64'(exp_dz));
        chk_eq({tag, "_inv"}, 64'(bus.flag_inv), 64'(exp_inv));
        if (hold > 0) begin
            bus.in_valid = 1'b1;
            bus.a = 64'h3FF0000000000000;
            bus.b = 64'h3FF0000000000000;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                @(negedge clk);
                chk_eq({tag, "_hres"}, bus.result, exp_res);
                chk_eq({tag, "_hflg"}, {62'd0, bus.flag_dz, bus.flag_inv},
                       {62'd0, exp_dz, exp_inv});
                chk_eq({tag, "_hvld"}, 64'(bus.out_valid), 64'd1);
                chk_eq({tag, "_hrdy"}, 64'(bus.in_ready), 64'd0);
            end
            bus.in_valid  = 1'b0;
            bus.out_ready = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        chk_eq({tag, "_drop"}, 64'(bus.out_valid), 64'd0);
        chk_eq({tag, "_rdy1"}, 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        int seen;
        n_checks      = 0;
        n_errors      = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.a         = 64'd0;
        bus.b         = 64'd0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_eq("rst_rdy", 64'(bus.in_ready), 64'd0);
        chk_eq("rst_vld", 64'(bus.out_valid), 64'd0);
        chk_eq("rst_res", bus.result, 64'd0);
        chk_eq("rst_flg", {62'd0, bus.flag_dz, bus.flag_inv}, 64'd0);
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk_eq("rel_rdy", 64'(bus.in_ready), 64'd1);

        // Normal path
        run_op("six_two", 64'h4018000000000000, 64'h4000000000000000,
               64'h4008000000000000, 1'b0, 1'b0, 57, 0);
        run_op("one_three", 64'h3FF0000000000000, 64'h4008000000000000,
               64'h3FD5555555555555, 1'b0, 1'b0, 57, 0);
        run_op("neg_third", 64'hBFF0000000000000, 64'h4008000000000000,
               64'hBFD5555555555555, 1'b0, 1'b0, 57, 0);
        run_op("tenth", 64'h3FF0000000000000, 64'h4024000000000000,
               64'h3FB999999999999A, 1'b0, 1'b0, 57, 0);

        // Specials
        run_op("div_zero", 64'h3FF0000000000000, 64'h0000000000000000,
               64'h7FF0000000000000, 1'b1, 1'b0, 1, 0);
        run_op("zero_zero", 64'h0000000000000000, 64'h0000000000000000,
               64'h7FF8000000000000, 1'b0, 1'b1, 1, 0);
        run_op("five_inf", 64'h4014000000000000, 64'h7FF0000000000000,
               64'h0000000000000000, 1'b0, 1'b0, 1, 0);
        run_op("nan_in", 64'hFFF0000000000001, 64'h4000000000000000,
               64'h7FF8000000000000, 1'b0, 1'b1, 1, 0);

        // Range limits
        run_op("ovf", 64'h7FEFFFFFFFFFFFFF, 64'h3FE0000000000000,
               64'h7FF0000000000000, 1'b0, 1'b0, 57, 0);
        run_op("unf", 64'h0010000000000000, 64'h4000000000000000,
               64'h0000000000000000, 1'b0, 1'b0, 57, 0);

        // Backpressure
        @(negedge clk);
        bus.out_ready = 1'b0;
        run_op("bp", 64'h4018000000000000, 64'h4000000000000000,
               64'h4008000000000000, 1'b0, 1'b0, 57, 10);

        // Reset in the middle of a division
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.a = 64'h4018000000000000;
        bus.b = 64'h4000000000000000;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (19) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_eq("mrst_rdy0", 64'(bus.in_ready), 64'd0);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 70; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (i == 0) chk_eq("mrst_rdy1", 64'(bus.in_ready), 64'd1);
            if (bus.out_valid) seen++;
        end
        chk_eq("mrst_novld", 64'(seen), 64'd0);
        run_op("after_rst", 64'h4018000000000000, 64'h4000000000000000,
               64'h4008000000000000, 1'b0, 1'b0, 57, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
